// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared encodings for the RV32M multi-cycle sequencer.
//   md_op_e  : funct3 encoding of the M-extension operation
//   state_e  : sequencer FSM states
//   helpers  : operation class / operand signedness decode
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MdopMul    = 3'd0,
        MdopMulh   = 3'd1,
        MdopMulhsu = 3'd2,
        MdopMulhu  = 3'd3,
        MdopDiv    = 3'd4,
        MdopDivu   = 3'd5,
        MdopRem    = 3'd6,
        MdopRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic op_is_div(md_op_e op);
        return op inside {MdopDiv, MdopDivu, MdopRem, MdopRemu};
    endfunction

    // mul (low half) is sign-agnostic, so it is treated as unsigned.
    function automatic logic op_signed_a(md_op_e op);
        return op inside {MdopMulh, MdopMulhsu, MdopDiv, MdopRem};
    endfunction

    function automatic logic op_signed_b(md_op_e op);
        return op inside {MdopMulh, MdopDiv, MdopRem};
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: EX-stage request/result bundle for the multi-cycle MDU.
//   in_valid, md_op, A, B, flush : pipeline -> MDU
//   stall, out_valid, C          : MDU -> pipeline
interface mdu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic [2:0]      md_op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] C;

    modport master (
        output in_valid, md_op, A, B, flush,
        input  stall, out_valid, C
    );

    modport slave (
        input  in_valid, md_op, A, B, flush,
        output stall, out_valid, C
    );
endinterface

// File: rtl/mdu_seq_iter_core.sv
// mdu_iter_core: datapath of the sequencer.
//   clk, rstn          : clock, async active-low reset
//   load               : capture op, operand magnitudes and sign flags
//   step               : one multiply (shift-add) or divide (restoring) bit
//   fix                : sign-correct and select the final result into res
//   op, a, b           : operation and raw operands (used at load)
//   fast               : op completes without iterating (div by zero / overflow)
//   result             : registered result
module mdu_iter_core
    import mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            fast,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    md_op_e          op_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q, res_q;
    logic            neg_q;    // product / quotient negated
    logic            rneg_q;   // remainder takes dividend sign

    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs, fast_res;

    always_comb begin
        a_neg    = op_signed_a(op) & a[XLEN-1];
        b_neg    = op_signed_b(op) & b[XLEN-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        div_zero = op_is_div(op) && (b == '0);
        div_ovf  = (op inside {MdopDiv, MdopRem}) && (a == MinInt) && (b == '1);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = (op inside {MdopDiv, MdopDivu}) ? '1 : a;
        end else begin
            fast_res = (op == MdopDiv) ? MinInt : '0;
        end
    end

    // One iteration. Multiply: {hi,lo} holds partial product with the
    // multiplier shifting out of lo. Divide: hi is the partial remainder,
    // lo shifts dividend bits out and quotient bits in.
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_is_div(op_q)) begin
            if (!div_diff[XLEN]) begin
                hi_step = div_diff[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_step = div_shift[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        unique case (op_q)
            MdopMul:                         fix_res = prod_fix[XLEN-1:0];
            MdopMulh, MdopMulhsu, MdopMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
            MdopDiv, MdopDivu:               fix_res = neg_q ? -lo_q : lo_q;
            MdopRem, MdopRemu:               fix_res = rneg_q ? -hi_q : hi_q;
            default:                         fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q   <= MdopMul;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            res_q  <= '0;
        end else if (load) begin
            op_q   <= op;
            hi_q   <= '0;
            lo_q   <= a_abs;
            b_q    <= b_abs;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (fast) begin
                res_q <= fast_res;
            end
        end else if (step) begin
            hi_q <= hi_step;
            lo_q <= lo_step;
        end else if (fix) begin
            res_q <= fix_res;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide sequencer beside the EX-stage alu.
//   clk, rstn : clock, async active-low reset
//   bus       : mdu_seq_if slave (in_valid, md_op, A, B, flush -> stall, out_valid, C)
// Accepts in IDLE, iterates XLEN cycles in CALC, sign-fixes in FIX and
// strobes the result for one cycle in DONE. Fast paths skip to DONE.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic clk,
    input  logic rstn,
    mdu_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, fast;
    logic             load, step, fix;
    logic             stall, out_valid;
    logic [XLEN-1:0]  result;

    assign accept = (state_q == StIdle) & bus.in_valid & ~bus.flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = fast ? StDone : StCalc;
                    cnt_d   = CNT_W'(XLEN - 1);
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFix:  state_d = bus.flush ? StIdle : StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The acceptance cycle stalls combinationally; DONE releases the pipe
    // for exactly one advance carrying C.
    always_comb begin
        load      = accept;
        step      = (state_q == StCalc) & ~bus.flush;
        fix       = (state_q == StFix) & ~bus.flush;
        stall     = accept | (state_q == StCalc) | (state_q == StFix);
        out_valid = (state_q == StDone) & ~bus.flush;
    end

    mdu_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .load   (load),
        .step   (step),
        .fix    (fix),
        .op     (md_op_e'(bus.md_op)),
        .a      (bus.A),
        .b      (bus.B),
        .fast   (fast),
        .result (result)
    );

    assign bus.stall     = stall;
    assign bus.out_valid = out_valid;
    assign bus.C         = result;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.XLEN(32)) bus ();

    mdu_seq #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op for a single cycle, scramble operands afterwards, and wait
    // (bounded) for the result strobe. stall_ok drops if stall is wrong anywhere.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] c, output int lat, output logic stall_ok);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.md_op    = op;
        bus.A        = a;
        bus.B        = b;
        @(negedge clk);
        stall_ok = bus.stall;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.B        = $urandom;
        lat = -1;
        c   = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (lat < 0) begin
                if (bus.out_valid) begin
                    lat = n;
                    c   = bus.C;
                    if (bus.stall) stall_ok = 1'b0;
                end else if (!bus.stall) begin
                    stall_ok = 1'b0;
                end
            end
        end
    endtask

    logic [31:0] c, a, b;
    logic [2:0]  op;
    int          lat, seen;
    logic        sok;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};
        vecs[14] = '{3'd3, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 34};
        vecs[15] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};

        bus.in_valid = 1'b0;
        bus.md_op    = 3'd0;
        bus.A        = '0;
        bus.B        = '0;
        bus.flush    = 1'b0;
        rstn         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_stall", {31'b0, bus.stall}, 32'd0);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_c", bus.C, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, c, lat, sok);
            check($sformatf("vec%0d_c", i), c, vecs[i].c);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_stall", i), {31'b0, sok}, 32'd1);
        end

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(op, a, b, c, lat, sok);
            check($sformatf("rnd%0d_op%0d_c", i, op), c, model(op, a, b));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(op, a, b)));
        end

        // in_valid held through DONE: not accepted there, accepted next IDLE.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.md_op = 3'd5; bus.A = 32'd5; bus.B = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_done_valid", {31'b0, bus.out_valid}, 32'd1);
        check("b2b_done_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        check("b2b_idle_valid", {31'b0, bus.out_valid}, 32'd0);
        check("b2b_idle_stall", {31'b0, bus.stall}, 32'd1);
        @(negedge clk);
        check("b2b_second_valid", {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Flush at T+10 of a divide.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.md_op = 3'd4; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_idle_stall", {31'b0, bus.stall}, 32'd0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, c, lat, sok);
        check("post_flush_c", c, 32'd12);
        check("post_flush_lat", 32'(lat), 32'd34);

        // Reset at T+20 of a multiply.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.md_op = 3'd0; bus.A = 32'd1000; bus.B = 32'd1000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midrst_stall", {31'b0, bus.stall}, 32'd0);
        check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_c", bus.C, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.out_valid || bus.stall) seen++;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        run_op(3'd5, 32'd9, 32'd3, c, lat, sok);
        check("post_rst_c", c, 32'd3);
        check("post_rst_lat", 32'(lat), 32'd34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide/remainder ops that the single-cycle alu cannot execute.
- Sits beside alu in the EX stage and takes the same forwarded operands.
- Holds the pipeline via a stall output while it iterates, then presents one result for EX/MEM writeback.
- Iterative shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  EX holds an M-extension instruction.
- md_op  input  3  funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- A  input  XLEN  rs1 operand (forwarded).
- B  input  XLEN  rs2 operand (forwarded).
- flush  input  1  kill in-flight op (branch/exception flush).
- stall  output  1  freeze PC, IF/ID and ID/EX.
- out_valid  output  1  one-cycle result strobe.
- C  output  XLEN  result; valid only while out_valid=1.

Behaviour:
- Async reset (rstn=0): state IDLE, counter 0, internal regs 0, stall=0, out_valid=0, C=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Acceptance when in_valid=1 and flush=0 (cycle T).
  - Latch op, operands as absolute values where signed, and result-sign flags.
- Fast paths, taken at acceptance, go directly to DONE at T+1:
  - Divide-by-zero: div/divu quotient = all ones; rem/remu = A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): div = 0x80000000; rem = 0.
- Normal path:
  - CALC for cycles T+1..T+32, counter counting XLEN-1 down to 0.
  - Multiply: 2*XLEN-bit product, shift-add, one bit per cycle.
  - Divide: restoring divide, one quotient bit per cycle.
- FIX at T+33:
  - Two's-complement negate the product if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Select low half (mul) or high half (mulh/mulhsu/mulhu), quotient or remainder.
- DONE at T+34: out_valid=1, C=result, stall=0; next state IDLE.
- stall = (IDLE & in_valid & ~flush) | CALC | FIX.
  - Combinational in IDLE so the acceptance cycle is itself stalled.
  - stall is 0 in DONE, so the pipeline advances exactly once with C.
- out_valid is 1 only in DONE. C holds its last value otherwise but is don't-care.
- Operand capture: A and B are sampled only at acceptance; later changes are ignored.
- flush in CALC/FIX/DONE: next state IDLE, out_valid forced 0 that cycle, no result emitted.
- flush in IDLE: no acceptance.
- Back-to-back ops: in_valid high in the DONE cycle is not accepted. The next op is accepted in the following IDLE cycle.
- rstn asserted mid-operation: immediate return to reset values, no output.
- Width rules:
  - mulhsu: A signed, B unsigned.
  - Unsigned ops never negate.
  - All arithmetic done on XLEN+1 or 2*XLEN bits, no truncation before FIX.

Decomposition:
- md_op encodings (MDOP_MUL..MDOP_REMU) and state encodings go in ctrl_encode_def.v as defines, alongside the ALUOp codes.
- Sub-module: mdu_iter_core, holding the shift/add/subtract registers and one-step logic. Controlled by load/step/fix strobes from mdu_seq's FSM.

Test Plan:
- mul A=7, B=-3 -> stall 1 for cycles T..T+33; out_valid at T+34; C=0xFFFFFFEB; stall 0 at T+34.
- mulhu A=0xFFFFFFFF, B=0xFFFFFFFF -> C=0xFFFFFFFE. mulh on the same operands -> C=0x00000000. mulhsu A=-1, B=2 -> C=0xFFFFFFFF.
- div A=-7, B=2 -> C=0xFFFFFFFD (-3). rem on the same operands -> C=0xFFFFFFFF (-1). divu A=100, B=7 -> C=14. remu on the same operands -> C=2.
- divu A=5, B=0 -> out_valid at T+1, C=0xFFFFFFFF. rem A=5, B=0 -> C=5. div A=0x80000000, B=-1 -> out_valid at T+1, C=0x80000000.
- div started, flush pulsed at T+10 -> IDLE at T+11, out_valid never asserted, stall 0. A new mul with A=3, B=4 accepted next -> C=12 at acceptance+34.
- rstn driven low at T+20 of a mul -> stall, out_valid, C are 0 immediately. After release, a fresh divu A=9, B=3 -> C=3.
